rotl_pipe_nbit: RTL and testbench

Pipelined N-bit circular left rotator with valid/ready handshakes on both sides. It is the inverse of the team's combinational right rotator: rotating a word right by k and then through this block by k returns the original word. It sits in streaming datapaths that need a registered, backpressure-aware rotation and one result per clock at full throughput.

---
 rtl/rotl_pkg.sv | 29 ++
 rtl/rotl_stage.sv | 46 ++++
 rtl/rotl_pipe_nbit.sv | 80 ++++++++
 tb/tb_rotl_pipe_nbit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotl_pkg.sv
// Shared types and the reference rotation function for the pipelined left rotator.
// The payload is sized for the widest supported word; unused upper bits stay zero.
package rotl_pkg;

  localparam int unsigned ROTL_MAX_W = 64;
  localparam int unsigned ROTL_MAX_S = 6;

  typedef struct packed {
    logic [ROTL_MAX_W-1:0] word;
    logic [ROTL_MAX_S-1:0] amt;
  } rotl_payload_t;

  // Rotate the low `width` bits of word left by amt; bits at and above width come back zero.
  function automatic logic [ROTL_MAX_W-1:0] rotl(input logic [ROTL_MAX_W-1:0] word,
                                                 input int unsigned amt,
                                                 input int unsigned width);
    logic [ROTL_MAX_W-1:0] res;
    logic [ROTL_MAX_S-1:0] src;
    logic [ROTL_MAX_S-1:0] dst;
    res = '0;
    for (int unsigned i = 0; i < ROTL_MAX_W; i++) begin
      src = ROTL_MAX_S'(i);
      dst = ROTL_MAX_S'((i + amt) % width);
      if (i < width) res[dst] = word[src];
    end
    return res;
  endfunction

endpackage

// File: rtl/rotl_stage.sv
// One pipeline stage of the logarithmic rotator: rotates left by 2^K when amount bit K
// is set, and owns its valid bit and skid-free ready term.
module rotl_stage
  import rotl_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned K = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  rotl_payload_t in_data,
  output logic          in_ready,
  output logic          out_valid,
  output rotl_payload_t out_data,
  input  logic          out_ready
);

  localparam int unsigned STEP = 1 << K;

  logic          valid_q;
  rotl_payload_t data_q;
  rotl_payload_t data_d;

  always_comb begin
    data_d = in_data;
    if (in_data.amt[K]) data_d.word = rotl(in_data.word, STEP, N);
  end

  // An empty stage always accepts, so bubbles collapse behind a stalled tail.
  assign in_ready = !valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/rotl_pipe_nbit.sv
// Pipelined N-bit circular left rotator: S = log2(N) registered stages, one word per clock.
// Handshake: a word moves across a boundary on a clock edge only when valid and ready are
// both high there; valid never depends on ready, and a holder keeps data stable until taken.
module rotl_pipe_nbit
  import rotl_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inValid,
  output logic         inReady,
  input  logic [N-1:0] a,
  input  logic [S-1:0] shiftAmount,
  output logic         outValid,
  input  logic         outReady,
  output logic [N-1:0] rotated
);

  rotl_payload_t in_payload;

  always_comb begin
    in_payload                  = '0;
    in_payload.word[N-1:0]      = a;
    in_payload.amt[S-1:0]       = shiftAmount;
  end

  // Each stage gets its own named wires so the backward ready chain stays acyclic per signal.
  for (genvar k = 0; k < S; k++) begin : g_stage
    logic          in_valid_w;
    logic          in_ready_w;
    logic          out_valid_w;
    logic          out_ready_w;
    rotl_payload_t in_data_w;
    rotl_payload_t out_data_w;

    if (k == 0) begin : g_first
      assign in_valid_w = inValid;
      assign in_data_w  = in_payload;
    end else begin : g_mid
      assign in_valid_w = g_stage[k-1].out_valid_w;
      assign in_data_w  = g_stage[k-1].out_data_w;
    end

    if (k == S - 1) begin : g_last
      assign out_ready_w = outReady;
    end else begin : g_next
      assign out_ready_w = g_stage[k+1].in_ready_w;
    end

    rotl_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_w),
      .in_data   (in_data_w),
      .in_ready  (in_ready_w),
      .out_valid (out_valid_w),
      .out_data  (out_data_w),
      .out_ready (out_ready_w)
    );
  end

  assign inReady  = g_stage[0].in_ready_w;
  assign outValid = g_stage[S-1].out_valid_w;
  assign rotated  = g_stage[S-1].out_data_w.word[N-1:0];

  // The spent amount and the zero padding above N are not needed past the last stage.
  logic unused_payload;
  if (N < ROTL_MAX_W) begin : g_pad
    assign unused_payload = ^{g_stage[S-1].out_data_w.word[ROTL_MAX_W-1:N],
                              g_stage[S-1].out_data_w.amt};
  end else begin : g_nopad
    assign unused_payload = ^g_stage[S-1].out_data_w.amt;
  end

endmodule

// File: tb/tb_rotl_pipe_nbit.sv
// Bench for rotl_pipe_nbit (N=8): directed vector table, back-to-back, backpressure,
// random handshake traffic and mid-stream reset, with an expected-queue scoreboard.
module tb_rotl_pipe_nbit;

  localparam int N = 8;
  localparam int S = 3;
  localparam int W = 2 * N + S;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [N-1:0] a = '0;
  logic [S-1:0] shiftAmount = '0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [N-1:0] rotated;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] a;
    logic [S-1:0] amt;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  rotl_pipe_nbit #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inValid     (inValid),
    .inReady     (inReady),
    .a           (a),
    .shiftAmount (shiftAmount),
    .outValid    (outValid),
    .outReady    (outReady),
    .rotated     (rotated)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] model_rotl(input logic [N-1:0] w, input int k);
    logic [N-1:0] r;
    r = (k == 0) ? w : ((w << k) | (w >> (N - k)));
    return r;
  endfunction

  function automatic logic [N-1:0] model_rotr(input logic [N-1:0] w, input int k);
    logic [N-1:0] r;
    r = (k == 0) ? w : ((w >> k) | (w << (N - k)));
    return r;
  endfunction

  // Scoreboard: sampled at the falling edge, so each observation is the transfer about to happen.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (outValid && outReady) begin
        check("out_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_word", 32'(rotated), 32'(e[W-1 -: N]));
          check("round_trip", 32'(model_rotr(rotated, int'(e[S-1:0]))), 32'(e[S +: N]));
        end
      end
      if (inValid && inReady)
        exp_q.push_back({model_rotl(a, int'(shiftAmount)), a, shiftAmount});
    end
  end

  task automatic send_one(input logic [N-1:0] wa, input logic [S-1:0] wamt,
                          input logic [N-1:0] wexp, input string name);
    int lat;
    @(posedge clk); #1;
    outReady    = 1'b1;
    inValid     = 1'b1;
    a           = wa;
    shiftAmount = wamt;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(inReady), 1);
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (outValid) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), 3);
    check({name, "_value"}, 32'(rotated), 32'(wexp));
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int sent;
    int cyc;
    int ovc;
    bit took;
    bit have_hold;
    logic [N-1:0] hold;
    logic [13:0] ov;
    logic [N-1:0] bp_a[12];

    vecs[0] = '{8'h81, 3'd1, 8'h03};
    vecs[1] = '{8'hB4, 3'd0, 8'hB4};
    vecs[2] = '{8'hB4, 3'd3, 8'hA5};
    vecs[3] = '{8'h01, 3'd7, 8'h80};
    vecs[4] = '{8'h80, 3'd1, 8'h01};
    vecs[5] = '{8'h12, 3'd4, 8'h21};
    vecs[6] = '{8'h5A, 3'd2, 8'h69};
    vecs[7] = '{8'hFF, 3'd5, 8'hFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(outValid), 0);
    check("reset_rotated", 32'(rotated), 0);
    check("reset_in_ready", 32'(inReady), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table, one word at a time
    for (int i = 0; i < 8; i++)
      send_one(vecs[i].a, vecs[i].amt, vecs[i].exp, $sformatf("vec%0d", i));

    // Back-to-back: eight words, no bubbles on the output
    outReady = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      inValid     = (c < 8);
      a           = N'(c * 37 + 5);
      shiftAmount = S'(c);
      @(negedge clk);
      ov[c] = outValid;
    end
    check("b2b_valid_pattern", 32'(ov), 32'(14'h07F8));

    // Exhaustive sweep at full rate
    for (int v = 0; v < 256; v++) begin
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        inValid     = 1'b1;
        a           = N'(v);
        shiftAmount = S'(k);
      end
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("sweep_drained", 32'(exp_q.size()), 0);

    // Backpressure: fill while the sink is stalled, then release
    for (int i = 0; i < 12; i++) bp_a[i] = N'(8'h1D * (i + 1));
    outReady  = 1'b0;
    acc       = 0;
    have_hold = 1'b0;
    hold      = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      inValid     = 1'b1;
      a           = bp_a[acc];
      shiftAmount = S'(acc);
      @(negedge clk);
      if (inReady) acc++;
      if (outValid) begin
        if (!have_hold) begin
          hold      = rotated;
          have_hold = 1'b1;
        end else begin
          check("stall_hold", 32'(rotated), 32'(hold));
        end
      end
    end
    check("bp_accepted", 32'(acc), 3);
    check("bp_in_ready_full", 32'(inReady), 0);
    check("bp_out_valid", 32'(outValid), 1);
    check("bp_head_word", 32'(hold), 32'(model_rotl(bp_a[0], 0)));
    @(posedge clk); #1;
    outReady    = 1'b1;
    a           = bp_a[acc];
    shiftAmount = S'(acc);
    @(negedge clk);
    check("release_in_ready", 32'(inReady), 1);
    if (inReady) acc++;
    for (int c = 0; c < 30 && acc < 8; c++) begin
      @(posedge clk); #1;
      a           = bp_a[acc];
      shiftAmount = S'(acc);
      @(negedge clk);
      if (inReady) acc++;
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    check("bp_all_sent", 32'(acc), 8);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("bp_drained", 32'(exp_q.size()), 0);

    // Random valid/ready traffic
    sent = 0;
    took = 1'b0;
    cyc  = 0;
    inValid = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        sent++;
        inValid = 1'b0;
      end
      if (sent < 10000 && !inValid) begin
        inValid = 1'($urandom_range(0, 1));
        if (inValid) begin
          a           = N'($urandom_range(0, 255));
          shiftAmount = S'($urandom_range(0, 7));
        end
      end
      if (sent >= 10000) inValid = 1'b0;
      outReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      took = inValid && inReady;
    end
    check("rand_sent", 32'(sent), 10000);
    @(posedge clk); #1;
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("rand_drained", 32'(exp_q.size()), 0);

    // Reset with three words in flight
    outReady = 1'b0;
    acc = 0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      @(posedge clk); #1;
      inValid     = 1'b1;
      a           = N'(8'hA0 + acc);
      shiftAmount = S'(acc + 1);
      @(negedge clk);
      if (inReady) acc++;
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    check("mid_fill_out_valid", 32'(outValid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 32'(outValid), 0);
    check("mid_reset_rotated", 32'(rotated), 0);
    check("mid_reset_in_ready", 32'(inReady), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_one(8'hC3, 3'd2, 8'h0F, "post_reset");
    ovc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (outValid) ovc++;
    end
    check("no_stale_words", 32'(ovc), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
